// File: rtl/slice_height_engine.sv
// -----------------------------------------------------------------------------
// slice_height_engine
//
// Computes the projected wall-slice height for one screen column of a
// ray-casting renderer:
//   beta  = column*ANG_STEP - (NUM_COLS*ANG_STEP)/2      (signed ray offset)
//   alpha = view_angle + beta  (mod 2^ANGLE_W)           (absolute ray angle)
//   d     = nearer of the asserted horizontal / vertical wall hits
//   dc    = (d * cos|beta|) >> FRAC_W                    (fish-eye corrected)
//   h     = min(PROJ_CONST / dc, 2^HEIGHT_W-1)
// No hit or an out-of-range column gives h = 0; dc = 0 gives the maximum.
//
// Ports
//   clock, resetn       rising-edge clock, synchronous active-low reset
//   start/start_ready   request a column; start_ready is high only in IDLE
//   column_in           screen column, sampled with start
//   view_angle          player heading, sampled with start
//   cos_addr/cos_data   external cosine LUT; cos_addr = |beta|, data sampled
//                       at the end of COS (Q1.FRAC_W unsigned)
//   ray_req/ray_ack     wall-intersection request; ray_angle = alpha
//   hit_h/hit_v         wall found on horizontal / vertical grid
//   dist_h/dist_v       raw distances, captured with ray_ack
//   out_valid/out_ready result handshake; slice_height holds the result
//   state_dbg           current FSM state encoding
//   side                (SLICE_SIDE_EN only) 0 = horizontal, 1 = vertical hit
//
// Configuration macro: SLICE_SIDE_EN adds the side output and its register.
//
// Handshakes: every req/valid output stays asserted with its payload stable
// until the matching ack/ready is sampled high on a rising clock edge; the
// transfer happens on that edge and the output drops in the following cycle.
// start is only honoured while start_ready is high.
// -----------------------------------------------------------------------------
module slice_height_engine #(
  parameter int ANGLE_W    = 10,
  parameter int COL_W      = 8,
  parameter int NUM_COLS   = 160,
  parameter int ANG_STEP   = 1,
  parameter int DIST_W     = 13,
  parameter int FRAC_W     = 9,
  parameter int HEIGHT_W   = 7,
  parameter int PROJ_CONST = 8896,
  parameter int PROJ_W     = 14
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  output logic                start_ready,
  input  logic [COL_W-1:0]    column_in,
  input  logic [ANGLE_W-1:0]  view_angle,
  output logic [ANGLE_W-2:0]  cos_addr,
  input  logic [FRAC_W:0]     cos_data,
  output logic                ray_req,
  output logic [ANGLE_W-1:0]  ray_angle,
  input  logic                ray_ack,
  input  logic                hit_h,
  input  logic                hit_v,
  input  logic [DIST_W-1:0]   dist_h,
  input  logic [DIST_W-1:0]   dist_v,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [HEIGHT_W-1:0] slice_height,
  output logic [2:0]          state_dbg
`ifdef SLICE_SIDE_EN
  ,
  output logic                side
`endif
);

  localparam int HALF_SPAN = (NUM_COLS * ANG_STEP) / 2;
  localparam int CNT_W     = (PROJ_W > 1) ? $clog2(PROJ_W) : 1;
  localparam int PROD_W    = DIST_W + FRAC_W + 1;

  localparam logic [COL_W:0]        NUM_COLS_L = (COL_W + 1)'(NUM_COLS);
  localparam logic [PROJ_W-1:0]     PROJ_L     = PROJ_W'(PROJ_CONST);
  localparam logic [PROJ_W-1:0]     H_MAX_Q    = PROJ_W'((2 ** HEIGHT_W) - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(PROJ_W - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ANGLE   = 3'd1,
    S_COS     = 3'd2,
    S_RAY     = 3'd3,
    S_SELECT  = 3'd4,
    S_CORRECT = 3'd5,
    S_DIVIDE  = 3'd6,
    S_OUT     = 3'd7
  } state_t;

  state_t state, state_next;

  // Latched request
  logic [COL_W-1:0]   col_q;
  logic [ANGLE_W-1:0] view_q;

  // Angle stage
  logic [ANGLE_W-1:0] beta_q;
  logic [ANGLE_W-1:0] alpha_q;

  // Cosine and ray results
  logic [FRAC_W:0]    cos_q;
  logic               hit_h_q;
  logic               hit_v_q;
  logic [DIST_W-1:0]  dist_h_q;
  logic [DIST_W-1:0]  dist_v_q;

  // Selected and corrected distance
  logic [DIST_W-1:0]  d_q;
  logic [DIST_W-1:0]  dc_q;

  // Restoring divider
  logic [DIST_W:0]    rem_q;
  logic [PROJ_W-1:0]  dvd_q;
  logic [PROJ_W-1:0]  quo_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [HEIGHT_W-1:0] height_q;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic signed [31:0]  beta_wide;
  logic [ANGLE_W-1:0]  beta_n;
  logic [ANGLE_W-1:0]  beta_abs;
  logic                col_oor;
  logic                any_hit;
  logic                pick_v;
  logic [DIST_W-1:0]   d_sel;
  logic [PROD_W-1:0]   prod;
  logic [DIST_W-1:0]   dc_n;
  logic [DIST_W:0]     rem_shift;
  logic                rem_ge;
  logic [DIST_W:0]     rem_n;
  logic [PROJ_W-1:0]   quo_n;
  logic [HEIGHT_W-1:0] quo_sat;
  logic                div_last;

  assign beta_wide = $signed(32'(col_q)) * ANG_STEP - HALF_SPAN;
  assign beta_n    = beta_wide[ANGLE_W-1:0];
  assign col_oor   = ({1'b0, col_q} >= NUM_COLS_L);

  // |beta| from the registered two's-complement value, so cos_addr is held
  // for as long as beta_q is.
  assign beta_abs  = beta_q[ANGLE_W-1] ? (~beta_q + 1'b1) : beta_q;

  // Both hits: vertical wins only when strictly nearer.
  assign any_hit = hit_h_q | hit_v_q;
  assign pick_v  = hit_v_q & (~hit_h_q | (dist_v_q < dist_h_q));
  assign d_sel   = pick_v ? dist_v_q : dist_h_q;

  assign prod = PROD_W'(d_q) * PROD_W'(cos_q);
  assign dc_n = prod[FRAC_W +: DIST_W];

  // Partial remainder stays below dc_q (< 2^DIST_W), so its top bit can be
  // dropped before shifting in the next dividend bit.
  assign rem_shift = {rem_q[DIST_W-1:0], dvd_q[PROJ_W-1]};
  assign rem_ge    = (rem_shift >= {1'b0, dc_q});
  assign rem_n     = rem_ge ? (rem_shift - {1'b0, dc_q}) : rem_shift;
  assign quo_n     = {quo_q[PROJ_W-2:0], rem_ge};
  assign quo_sat   = (quo_n > H_MAX_Q) ? {HEIGHT_W{1'b1}} : quo_n[HEIGHT_W-1:0];
  assign div_last  = (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_ANGLE;
      S_ANGLE:   state_next = col_oor ? S_OUT : S_COS;
      S_COS:     state_next = S_RAY;
      S_RAY:     if (ray_ack) state_next = S_SELECT;
      S_SELECT:  state_next = any_hit ? S_CORRECT : S_OUT;
      S_CORRECT: state_next = (dc_n == '0) ? S_OUT : S_DIVIDE;
      S_DIVIDE:  if (div_last) state_next = S_OUT;
      S_OUT:     if (out_ready) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!resetn) begin
      col_q    <= '0;
      view_q   <= '0;
      beta_q   <= '0;
      alpha_q  <= '0;
      cos_q    <= '0;
      hit_h_q  <= 1'b0;
      hit_v_q  <= 1'b0;
      dist_h_q <= '0;
      dist_v_q <= '0;
      d_q      <= '0;
      dc_q     <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      height_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            col_q  <= column_in;
            view_q <= view_angle;
          end
        end
        S_ANGLE: begin
          beta_q  <= beta_n;
          alpha_q <= view_q + beta_n;
          if (col_oor) height_q <= '0;
        end
        S_COS: begin
          cos_q <= cos_data;
        end
        S_RAY: begin
          if (ray_ack) begin
            hit_h_q  <= hit_h;
            hit_v_q  <= hit_v;
            dist_h_q <= dist_h;
            dist_v_q <= dist_v;
          end
        end
        S_SELECT: begin
          d_q <= d_sel;
          if (!any_hit) height_q <= '0;
        end
        S_CORRECT: begin
          dc_q  <= dc_n;
          rem_q <= '0;
          dvd_q <= PROJ_L;
          quo_q <= '0;
          cnt_q <= '0;
          if (dc_n == '0) height_q <= {HEIGHT_W{1'b1}};
        end
        S_DIVIDE: begin
          rem_q <= rem_n;
          dvd_q <= {dvd_q[PROJ_W-2:0], 1'b0};
          quo_q <= quo_n;
          cnt_q <= cnt_q + 1'b1;
          if (div_last) height_q <= quo_sat;
        end
        default: ;
      endcase
    end
  end

`ifdef SLICE_SIDE_EN
  logic side_q;

  // Side follows the selected axis; no hit and out-of-range columns give 0.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      side_q <= 1'b0;
    end else if (state == S_ANGLE && col_oor) begin
      side_q <= 1'b0;
    end else if (state == S_SELECT) begin
      side_q <= any_hit & pick_v;
    end
  end

  assign side = side_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign start_ready  = (state == S_IDLE);
  assign ray_req      = (state == S_RAY);
  assign out_valid    = (state == S_OUT);
  assign ray_angle    = alpha_q;
  assign cos_addr     = beta_abs[ANGLE_W-2:0];
  assign slice_height = height_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_slice_height_engine.sv
// -----------------------------------------------------------------------------
// tb_slice_height_engine
//
// Directed bench for slice_height_engine. A driver task issues each column,
// answers the ray request after a chosen number of wait cycles and pushes the
// hand-computed height (and side) into exp_q. A monitor pops and compares on
// every out_valid && out_ready. Extra directed checks cover reset values,
// ray angle / cosine address, latency, back-pressure and reset mid-RAY.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_slice_height_engine;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic        start_ready;
  logic [7:0]  column_in;
  logic [9:0]  view_angle;
  logic [8:0]  cos_addr;
  logic [9:0]  cos_data;
  logic        ray_req;
  logic [9:0]  ray_angle;
  logic        ray_ack;
  logic        hit_h;
  logic        hit_v;
  logic [12:0] dist_h;
  logic [12:0] dist_v;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  slice_height;
  logic [2:0]  state_dbg;
`ifdef SLICE_SIDE_EN
  logic        side;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  slice_height_engine dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .start_ready  (start_ready),
    .column_in    (column_in),
    .view_angle   (view_angle),
    .cos_addr     (cos_addr),
    .cos_data     (cos_data),
    .ray_req      (ray_req),
    .ray_angle    (ray_angle),
    .ray_ack      (ray_ack),
    .hit_h        (hit_h),
    .hit_v        (hit_v),
    .dist_h       (dist_h),
    .dist_v       (dist_v),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .slice_height (slice_height),
    .state_dbg    (state_dbg)
`ifdef SLICE_SIDE_EN
    ,
    .side         (side)
`endif
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- checker ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [7:0] e;
    if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("slice_height", int'(slice_height), int'(e[6:0]));
`ifdef SLICE_SIDE_EN
        chk("side", int'(side), int'(e[7]));
`endif
      end
    end
  end

  // ---------------- driver ----------------
  // Runs one column. lat = edges from the start-sampling edge until out_valid
  // is seen; ack_n = same count at the cycle ray_ack was raised (-1 if none).
  task automatic run_txn(input int col, input int view, input int cosv,
                         input int hh, input int dh, input int hv, input int dv,
                         input int w, input int exp_h, input int exp_side,
                         input bit exp_ray, input int exp_angle, input int exp_addr,
                         output int lat, output int ack_n);
    int  n;
    int  wcnt;
    bit  acked;
    bit  saw_ray;
    n = 0; wcnt = 0; acked = 0; saw_ray = 0; ack_n = -1;
    while (!start_ready && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (!start_ready) chk("idle_timeout", 0, 1);
    cos_data   = 10'(cosv);
    column_in  = 8'(col);
    view_angle = 10'(view);
    start      = 1'b1;
    exp_q.push_back({1'(exp_side), 7'(exp_h)});
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      if (ray_ack) ray_ack = 1'b0;
      if (ray_req && !acked) begin
        if (!saw_ray) begin
          saw_ray = 1;
          chk("ray_angle", int'(ray_angle), exp_angle);
          chk("cos_addr", int'(cos_addr), exp_addr);
        end
        if (wcnt == w) begin
          hit_h   = 1'(hh);
          dist_h  = 13'(dh);
          hit_v   = 1'(hv);
          dist_v  = 13'(dv);
          ray_ack = 1'b1;
          acked   = 1;
          ack_n   = n;
        end else begin
          wcnt++;
        end
      end
      @(posedge clock); #1;
      n++;
    end
    ray_ack = 1'b0;
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    chk("ray_req_seen", int'(saw_ray), int'(exp_ray));
    lat = n;
    if (out_ready) begin
      @(posedge clock); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int ack_n;
    int seen;
    resetn = 1'b0; start = 1'b0; column_in = '0; view_angle = '0;
    cos_data = '0; ray_ack = 1'b0; hit_h = 1'b0; hit_v = 1'b0;
    dist_h = '0; dist_v = '0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_start_ready", int'(start_ready), 1);
    chk("rst_ray_req", int'(ray_req), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_slice_height", int'(slice_height), 0);
    chk("rst_ray_angle", int'(ray_angle), 0);
    chk("rst_cos_addr", int'(cos_addr), 0);
`ifdef SLICE_SIDE_EN
    chk("rst_side", int'(side), 0);
`endif
    resetn = 1'b1;
    @(posedge clock); #1;

    // Centre column, both hits, horizontal nearer: 8896/100 = 88.
    run_txn(80, 0, 512, 1, 100, 1, 200, 0, 88, 0, 1, 0, 0, lat, ack_n);
    chk("latency_w0", lat, 19);

    // Column 0, heading 10: beta -80, alpha wraps to 954; cos 0.5:
    // dc = 300*256>>9 = 150, 8896/150 = 59. Three wait cycles.
    run_txn(0, 10, 256, 1, 300, 0, 0, 3, 59, 0, 1, 954, 80, lat, ack_n);
    chk("latency_w3", lat, 22);

    // No hit: height 0, OUT two edges after the ack edge.
    run_txn(80, 0, 512, 0, 100, 0, 100, 1, 0, 0, 1, 0, 0, lat, ack_n);
    chk("nohit_gap", lat - ack_n, 2);

    // Vertical only, dist 10: 889 saturates to 127.
    run_txn(80, 0, 512, 0, 0, 1, 10, 0, 127, 1, 1, 0, 0, lat, ack_n);

    // Equal distances pick horizontal: 8896/200 = 44.
    run_txn(80, 0, 512, 1, 200, 1, 200, 2, 44, 0, 1, 0, 0, lat, ack_n);

    // Vertical nearer, cos 400: dc = 400*400>>9 = 312, 8896/312 = 28.
    run_txn(90, 20, 400, 1, 500, 1, 400, 0, 28, 1, 1, 30, 10, lat, ack_n);

    // dc truncates to 0 (1*256>>9): maximum height.
    run_txn(80, 0, 256, 1, 1, 0, 0, 0, 127, 0, 1, 0, 0, lat, ack_n);

    // Out-of-range column: height 0, no ray request.
    run_txn(200, 0, 512, 1, 100, 1, 100, 0, 0, 0, 0, 0, 0, lat, ack_n);

    // Last column, heading 1000: beta 79, alpha 1079 mod 1024 = 55;
    // 8896/1000 = 8.
    run_txn(159, 1000, 512, 1, 1000, 0, 0, 1, 8, 0, 1, 55, 79, lat, ack_n);

    // Far wall: 8896/8191 = 1.
    run_txn(80, 5, 512, 0, 0, 1, 8191, 0, 1, 1, 1, 5, 0, lat, ack_n);

    // Back-pressure: result held, new start ignored while in OUT.
    out_ready = 1'b0;
    run_txn(80, 0, 512, 1, 100, 1, 200, 0, 88, 0, 1, 0, 0, lat, ack_n);
    start = 1'b1; column_in = 8'd10; view_angle = 10'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_slice_height", int'(slice_height), 88);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp_back_idle", int'(start_ready), 1);
    @(posedge clock); #1;
    chk("bp_no_restart", int'(start_ready), 1);

    // Reset during RAY with no ack: back to IDLE after one edge.
    column_in = 8'd80; view_angle = 10'd0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !ray_req; i++) begin
      @(posedge clock); #1;
    end
    chk("rr_ray_req_up", int'(ray_req), 1);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b0;
    @(posedge clock); #1;
    chk("rr_ray_req", int'(ray_req), 0);
    chk("rr_start_ready", int'(start_ready), 1);
    chk("rr_slice_height", int'(slice_height), 0);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (out_valid) seen++;
    end
    chk("rr_no_partial", seen, 0);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
